cpu_run_controller: RTL and testbench
=====================================

Name: cpu_run_controller

Overview:
- Sequences CPU32 execution by issuing per-instruction clock-enable strobes: `ram_en` for the fetch phase, then `cpu_en` for the execute phase.
- Supports four modes: halt, free-run, single-step on button, and run-to-breakpoint.
- Sits between `clock_prescaler` (paced `tick`), `chattering_canceler` (debounced step button) and the CPU.
- Also drives status (`busy`, `bp_hit`) and an instruction counter for the LED debug display.

Parameters:
- PC_W, 32, width of the `pc` input and of `instr_cnt`.
- BP_W, 16, number of low `pc` bits compared against `bp_adrs`; must be <= PC_W.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- tick  input  1  one-cycle pacing strobe from the prescaler.
- mode  input  2  00 HALT, 01 RUN, 10 STEP, 11 RUN_BP.
- step_n  input  1  debounced step button, active low (level).
- bp_adrs  input  BP_W  breakpoint address.
- pc  input  PC_W  current CPU program counter.
- ram_en  output  1  one-cycle fetch-phase enable to the CPU/RAM.
- cpu_en  output  1  one-cycle execute-phase enable to the CPU.
- busy  output  1  high while an instruction is in flight (state != READY).
- bp_hit  output  1  sticky: breakpoint reached.
- instr_cnt  output  PC_W  count of completed instructions.

Behaviour:
- Reset (reset_n low at a clk edge):
  - state=READY; ram_en=0, cpu_en=0, busy=0, bp_hit=0, instr_cnt=0.
  - step_pending=0; step edge-detector history set to 1 (released).
- FSM states: READY -> FETCH -> EXEC -> CHECK -> READY. Each state lasts exactly one cycle except READY.
- Outputs per state:
  - ram_en=1 only in FETCH; cpu_en=1 only in EXEC.
  - The two strobes are never high together. Each is registered, so it is a single glitch-free cycle.
- Launch condition, evaluated only in READY and only when bp_hit=0 (otherwise stay in READY):
  - RUN: tick=1.
  - RUN_BP: tick=1.
  - STEP: step_pending=1. tick is ignored. step_pending clears on launch.
  - HALT: never.
- Latency: launch sampled at edge t; ram_en is high in cycle t+1, cpu_en in t+2, CHECK in t+3; READY is re-entered at t+4.
  - A tick arriving while busy is dropped; there is no tick queue.
  - Maximum rate is therefore one instruction per 4 clk cycles.
- Step detection:
  - A falling edge of step_n, registered in any state and any mode, sets step_pending (depth 1).
  - Further presses while step_pending=1 are absorbed.
  - step_pending clears on mode change away from STEP, so stale presses are not replayed.
- instr_cnt increments by 1 in the EXEC cycle and wraps from all-ones to 0.
- Breakpoint check:
  - In CHECK, if mode==RUN_BP and pc[BP_W-1:0]==bp_adrs, then set bp_hit. The pc sampled here is already updated by the cpu_en edge.
  - The compare happens only after execution. Launching RUN_BP while pc already equals bp_adrs executes at least one instruction.
- bp_hit clearing:
  - bp_hit clears on any change of mode (one-cycle registered previous-mode compare), or by reset.
  - While bp_hit=1 no launch occurs, even if mode stays RUN_BP.
- Mode change mid-instruction: the in-flight FETCH/EXEC/CHECK always completes. Mode is only consulted in READY and CHECK; an instruction is never split.
- Simultaneous events:
  - A mode change and the CHECK match in the same cycle: the match uses the current mode value, and the mode change clears bp_hit one cycle later.
  - Clear has priority over set only when both occur in the same cycle.
- Reset mid-instruction: the FSM returns to READY immediately. The aborted instruction's cpu_en is not emitted if reset lands in FETCH.

Decomposition:
- Shared defines file:
  - Mode encodings `MODE_HALT`, `MODE_RUN`, `MODE_STEP`, `MODE_RUN_BP`.
  - State encodings `ST_READY`, `ST_FETCH`, `ST_EXEC`, `ST_CHECK`, 2-bit.
- One sub-module: `falling_edge_detect` (registered history, one-cycle pulse output). Reusable for the other button inputs.

Test Plan:
- Reset then mode=RUN, tick every 8 cycles for 5 ticks -> 5 ram_en/cpu_en pairs, cpu_en exactly 1 cycle after ram_en; instr_cnt=5.
- mode=RUN, tick held high continuously for 40 cycles -> exactly 10 instructions, since ticks are dropped while busy.
- mode=STEP, two presses of step_n 2 cycles apart during one instruction -> that instruction plus exactly one more, then READY with busy=0.
- mode=RUN_BP, bp_adrs=0x000C, pc model +4 per cpu_en from 0x0000 -> bp_hit set after the pc=0x000C CHECK; instr_cnt=3; no further ram_en.
- With bp_hit=1, toggle mode RUN_BP->HALT->RUN_BP -> bp_hit clears; with pc=0x000C=bp_adrs, at least one instruction executes before the next stop.
- Drive reset_n low during the FETCH cycle -> no cpu_en, instr_cnt=0, busy=0 on the next cycle.

Source files
------------

// File: rtl/cpu_run_controller_pkg.sv
// rtl/cpu_run_controller_pkg.sv - shared mode/state encodings for the CPU run controller
//
// Purpose : mode and FSM state encodings plus a small mode helper.
// Ports   : none (package).

package cpu_run_controller_pkg;

  localparam logic [1:0] MODE_HALT   = 2'b00;
  localparam logic [1:0] MODE_RUN    = 2'b01;
  localparam logic [1:0] MODE_STEP   = 2'b10;
  localparam logic [1:0] MODE_RUN_BP = 2'b11;

  typedef enum logic [1:0] {
    ST_READY = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_CHECK = 2'd3
  } state_t;

  // Modes whose launches are paced by the prescaler tick.
  function automatic logic is_paced(input logic [1:0] mode);
    return (mode == MODE_RUN) || (mode == MODE_RUN_BP);
  endfunction

endpackage

// File: rtl/cpu_run_controller_if.sv
// rtl/cpu_run_controller_if.sv - control/status bundle between the run controller and its environment
//
// Purpose : groups pacing, mode, step button, breakpoint, pc and the
//           controller's strobes/status into one interface.
// Ports   : master drives tick/mode/step_n/bp_adrs/pc and observes the rest;
//           slave (the controller) does the opposite.

interface cpu_run_controller_if #(
  parameter int PC_W = 32,
  parameter int BP_W = 16
);
  logic            tick;
  logic [1:0]      mode;
  logic            step_n;
  logic [BP_W-1:0] bp_adrs;
  logic [PC_W-1:0] pc;
  logic            ram_en;
  logic            cpu_en;
  logic            busy;
  logic            bp_hit;
  logic [PC_W-1:0] instr_cnt;

  modport master (
    output tick, mode, step_n, bp_adrs, pc,
    input  ram_en, cpu_en, busy, bp_hit, instr_cnt
  );

  modport slave (
    input  tick, mode, step_n, bp_adrs, pc,
    output ram_en, cpu_en, busy, bp_hit, instr_cnt
  );
endinterface

// File: rtl/cpu_run_controller_falling_edge_detect.sv
// rtl/cpu_run_controller_falling_edge_detect.sv - falling-edge pulse from a debounced level
//
// Purpose : one-cycle pulse when din goes 1 -> 0; history resets to 1 so a
//           button held at reset is not seen as a press.
// Ports   : clk, reset_n (sync, active low), din (level), fall (pulse).

module falling_edge_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic fall
);

  logic hist;

  always_ff @(posedge clk) begin
    if (!reset_n) hist <= 1'b1;
    else          hist <= din;
  end

  assign fall = hist & ~din;

endmodule

// File: rtl/cpu_run_controller.sv
// rtl/cpu_run_controller.sv - fetch/execute strobe sequencer with halt/run/step/breakpoint modes
//
// Purpose : launches one instruction at a time as READY -> FETCH (ram_en) ->
//           EXEC (cpu_en) -> CHECK -> READY, paced by tick, the step button,
//           or stopped by a sticky breakpoint hit.
// Ports   : clk, reset_n (sync, active low);
//           bus (slave): tick, mode, step_n, bp_adrs, pc in;
//                        ram_en, cpu_en, busy, bp_hit, instr_cnt out.

module cpu_run_controller
  import cpu_run_controller_pkg::*;
#(
  parameter int PC_W = 32,
  parameter int BP_W = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  cpu_run_controller_if.slave   bus
);

  state_t          state;
  logic            ram_en_q;
  logic            cpu_en_q;
  logic            busy_q;
  logic            bp_hit_q;
  logic [PC_W-1:0] instr_cnt_q;
  logic [1:0]      prev_mode;
  logic            mode_chg_q;
  logic            step_pending;
  logic            step_fall;
  logic            launch;
  logic            bp_match;
  logic            leave_step;

  falling_edge_detect u_step_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (bus.step_n),
    .fall    (step_fall)
  );

  assign launch = (state == ST_READY) && !bp_hit_q &&
                  ((is_paced(bus.mode) && bus.tick) ||
                   ((bus.mode == MODE_STEP) && step_pending));

  // pc here already reflects the instruction just executed.
  assign bp_match = (bus.mode == MODE_RUN_BP) && (bus.pc[BP_W-1:0] == bus.bp_adrs);

  // Presses captured in STEP must not replay after leaving STEP.
  assign leave_step = (prev_mode == MODE_STEP) && (bus.mode != MODE_STEP);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= ST_READY;
      ram_en_q     <= 1'b0;
      cpu_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      bp_hit_q     <= 1'b0;
      instr_cnt_q  <= '0;
      prev_mode    <= MODE_HALT;
      mode_chg_q   <= 1'b0;
      step_pending <= 1'b0;
    end else begin
      prev_mode  <= bus.mode;
      mode_chg_q <= (bus.mode != prev_mode);
      ram_en_q   <= 1'b0;
      cpu_en_q   <= 1'b0;

      case (state)
        ST_READY: begin
          if (launch) begin
            state    <= ST_FETCH;
            ram_en_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        ST_FETCH: begin
          state       <= ST_EXEC;
          cpu_en_q    <= 1'b1;
          instr_cnt_q <= instr_cnt_q + PC_W'(1);
        end
        ST_EXEC: begin
          state <= ST_CHECK;
        end
        ST_CHECK: begin
          state  <= ST_READY;
          busy_q <= 1'b0;
          if (bp_match) bp_hit_q <= 1'b1;
        end
        default: begin
          state  <= ST_READY;
          busy_q <= 1'b0;
        end
      endcase

      // Registered mode-change clear wins over a same-cycle breakpoint set.
      if (mode_chg_q) bp_hit_q <= 1'b0;

      // Later assignments take priority: leave-STEP clear > new press > launch.
      if (launch && (bus.mode == MODE_STEP)) step_pending <= 1'b0;
      if (step_fall)                         step_pending <= 1'b1;
      if (leave_step)                        step_pending <= 1'b0;
    end
  end

  assign bus.ram_en    = ram_en_q;
  assign bus.cpu_en    = cpu_en_q;
  assign bus.busy      = busy_q;
  assign bus.bp_hit    = bp_hit_q;
  assign bus.instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// tb/tb_cpu_run_controller.sv - self-checking bench for cpu_run_controller

module tb_cpu_run_controller;
  import cpu_run_controller_pkg::*;

  logic clk;
  logic reset_n;

  cpu_run_controller_if #(.PC_W(32), .BP_W(16)) bus ();

  cpu_run_controller #(.PC_W(32), .BP_W(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CPU pc model: advances by 4 on every executed instruction.
  logic [31:0] pc_q;
  always @(posedge clk) begin
    if (!reset_n)        pc_q <= 32'h0;
    else if (bus.cpu_en) pc_q <= pc_q + 32'd4;
  end
  assign bus.pc = pc_q;

  int n_chk  = 0;
  int n_fail = 0;
  int ram_seen, cpu_seen, pair_bad;
  logic prev_ram;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clr_counts();
    ram_seen = 0;
    cpu_seen = 0;
    pair_bad = 0;
    prev_ram = 1'b0;
  endtask

  // One clock; outputs sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (bus.ram_en) ram_seen++;
    if (bus.cpu_en) cpu_seen++;
    if (bus.cpu_en !== prev_ram) pair_bad++;
    prev_ram = bus.ram_en;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    bus.tick   = 1'b0;
    bus.step_n = 1'b1;
    bus.mode   = MODE_HALT;
    cyc();
    cyc();
    reset_n = 1'b1;
    cyc();
    clr_counts();
  endtask

  typedef struct {
    logic        tick;
    logic [1:0]  mode;
    logic        ram;
    logic        cpu;
    logic        busy;
    logic        bp;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(input logic t, input logic [1:0] m, input logic r,
                              input logic c, input logic b, input logic [31:0] n);
    vec_t v;
    v.tick = t; v.mode = m; v.ram = r; v.cpu = c; v.busy = b; v.bp = 1'b0; v.cnt = n;
    return v;
  endfunction

  initial begin
    bus.bp_adrs = 16'h000C;
    bus.tick    = 1'b0;
    bus.step_n  = 1'b1;
    bus.mode    = MODE_HALT;
    clr_counts();

    //           tick  mode         ram  cpu  busy cnt
    tbl[0]  = mk(1'b0, MODE_RUN,    1'b0, 1'b0, 1'b0, 0);
    tbl[1]  = mk(1'b1, MODE_RUN,    1'b1, 1'b0, 1'b1, 0);
    tbl[2]  = mk(1'b1, MODE_RUN,    1'b0, 1'b1, 1'b1, 1);  // tick while busy dropped
    tbl[3]  = mk(1'b0, MODE_RUN,    1'b0, 1'b0, 1'b1, 1);
    tbl[4]  = mk(1'b0, MODE_RUN,    1'b0, 1'b0, 1'b0, 1);
    tbl[5]  = mk(1'b1, MODE_RUN,    1'b1, 1'b0, 1'b1, 1);
    tbl[6]  = mk(1'b0, MODE_RUN,    1'b0, 1'b1, 1'b1, 2);
    tbl[7]  = mk(1'b1, MODE_RUN,    1'b0, 1'b0, 1'b1, 2);
    tbl[8]  = mk(1'b1, MODE_RUN,    1'b0, 1'b0, 1'b0, 2);
    tbl[9]  = mk(1'b1, MODE_RUN,    1'b1, 1'b0, 1'b1, 2);
    tbl[10] = mk(1'b0, MODE_HALT,   1'b0, 1'b1, 1'b1, 3);  // in-flight completes
    tbl[11] = mk(1'b0, MODE_HALT,   1'b0, 1'b0, 1'b1, 3);
    tbl[12] = mk(1'b0, MODE_HALT,   1'b0, 1'b0, 1'b0, 3);
    tbl[13] = mk(1'b1, MODE_HALT,   1'b0, 1'b0, 1'b0, 3);
    tbl[14] = mk(1'b1, MODE_STEP,   1'b0, 1'b0, 1'b0, 3);  // tick ignored in STEP
    tbl[15] = mk(1'b1, MODE_RUN,    1'b1, 1'b0, 1'b1, 3);

    // Reset values while reset_n held low.
    reset_n = 1'b0;
    cyc();
    cyc();
    chk("rst_ram_en",    {31'b0, bus.ram_en}, 32'd0);
    chk("rst_cpu_en",    {31'b0, bus.cpu_en}, 32'd0);
    chk("rst_busy",      {31'b0, bus.busy},   32'd0);
    chk("rst_bp_hit",    {31'b0, bus.bp_hit}, 32'd0);
    chk("rst_instr_cnt", bus.instr_cnt,       32'd0);

    // Cycle-by-cycle table.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      bus.tick = tbl[i].tick;
      bus.mode = tbl[i].mode;
      cyc();
      chk($sformatf("tbl%0d_ram_en", i), {31'b0, bus.ram_en}, {31'b0, tbl[i].ram});
      chk($sformatf("tbl%0d_cpu_en", i), {31'b0, bus.cpu_en}, {31'b0, tbl[i].cpu});
      chk($sformatf("tbl%0d_busy", i),   {31'b0, bus.busy},   {31'b0, tbl[i].busy});
      chk($sformatf("tbl%0d_bp_hit", i), {31'b0, bus.bp_hit}, {31'b0, tbl[i].bp});
      chk($sformatf("tbl%0d_cnt", i),    bus.instr_cnt,       tbl[i].cnt);
    end

    // RUN, tick every 8 cycles, 5 ticks.
    do_reset();
    bus.mode = MODE_RUN;
    for (int i = 0; i < 5; i++) begin
      bus.tick = 1'b1;
      cyc();
      bus.tick = 1'b0;
      repeat (7) cyc();
    end
    chk("run8_ram_cnt",  ram_seen,      32'd5);
    chk("run8_cpu_cnt",  cpu_seen,      32'd5);
    chk("run8_pairing",  pair_bad,      32'd0);
    chk("run8_instr",    bus.instr_cnt, 32'd5);

    // RUN, tick held 40 cycles.
    do_reset();
    bus.mode = MODE_RUN;
    bus.tick = 1'b1;
    repeat (40) cyc();
    bus.tick = 1'b0;
    repeat (6) cyc();
    chk("hold_ram_cnt", ram_seen,      32'd10);
    chk("hold_cpu_cnt", cpu_seen,      32'd10);
    chk("hold_pairing", pair_bad,      32'd0);
    chk("hold_instr",   bus.instr_cnt, 32'd10);

    // STEP: one press launches, two presses during it give one more.
    do_reset();
    bus.mode = MODE_STEP;
    bus.tick = 1'b1;
    repeat (3) cyc();
    chk("step_tick_ignored", ram_seen, 32'd0);
    bus.step_n = 1'b0; cyc();
    bus.step_n = 1'b1; cyc();
    chk("step_launch_ram", {31'b0, bus.ram_en}, 32'd1);
    bus.step_n = 1'b0; cyc();
    bus.step_n = 1'b1; cyc();
    bus.step_n = 1'b0; cyc();
    bus.step_n = 1'b1;
    repeat (15) cyc();
    chk("step_ram_cnt", ram_seen,          32'd2);
    chk("step_instr",   bus.instr_cnt,     32'd2);
    chk("step_busy",    {31'b0, bus.busy}, 32'd0);
    chk("step_pairing", pair_bad,          32'd0);

    // Pending press is discarded when leaving STEP.
    do_reset();
    bus.mode = MODE_STEP;
    bus.step_n = 1'b0; cyc();
    bus.step_n = 1'b1; cyc();
    bus.step_n = 1'b0; cyc();
    bus.step_n = 1'b1;
    bus.mode = MODE_HALT;
    repeat (3) cyc();
    bus.mode = MODE_STEP;
    repeat (10) cyc();
    chk("step_stale_cleared", ram_seen, 32'd1);

    // RUN_BP stops after the instruction that lands pc on 0x000C.
    do_reset();
    bus.mode = MODE_RUN_BP;
    bus.tick = 1'b1;
    repeat (30) cyc();
    chk("bp_ram_cnt", ram_seen,            32'd3);
    chk("bp_instr",   bus.instr_cnt,       32'd3);
    chk("bp_hit_set", {31'b0, bus.bp_hit}, 32'd1);
    chk("bp_busy",    {31'b0, bus.busy},   32'd0);
    chk("bp_pc",      pc_q,                32'h0000_000C);

    // Mode toggle clears bp_hit; launching on the breakpoint pc executes.
    bus.tick = 1'b0;
    bus.mode = MODE_HALT;
    repeat (2) cyc();
    bus.mode = MODE_RUN_BP;
    repeat (3) cyc();
    chk("bp_cleared", {31'b0, bus.bp_hit}, 32'd0);
    clr_counts();
    bus.tick = 1'b1;
    repeat (4) cyc();
    bus.tick = 1'b0;
    repeat (6) cyc();
    chk("bp_resume_ram", ram_seen,            32'd1);
    chk("bp_resume_cnt", bus.instr_cnt,       32'd4);
    chk("bp_resume_hit", {31'b0, bus.bp_hit}, 32'd0);

    // Reset landing in FETCH aborts the instruction.
    do_reset();
    bus.mode = MODE_RUN;
    bus.tick = 1'b1; cyc();
    bus.tick = 1'b0;
    repeat (5) cyc();
    chk("rf_pre_cnt", bus.instr_cnt, 32'd1);
    bus.tick = 1'b1; cyc();
    bus.tick = 1'b0;
    chk("rf_in_fetch", {31'b0, bus.ram_en}, 32'd1);
    reset_n = 1'b0;
    cyc();
    chk("rf_cpu_en", {31'b0, bus.cpu_en}, 32'd0);
    chk("rf_busy",   {31'b0, bus.busy},   32'd0);
    chk("rf_cnt",    bus.instr_cnt,       32'd0);
    reset_n = 1'b1;
    cyc();
    chk("rf_after_cpu_en", {31'b0, bus.cpu_en}, 32'd0);
    chk("rf_after_busy",   {31'b0, bus.busy},   32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
